// File: rtl/segre_pkg.sv
// Shared types for the segre memory pipeline.
// Store-buffer drain FSM states and memory operand sizes live here.
package segre_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned BE_W    = WORD_W / 8;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } memop_data_type_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LOOKUP = 2'b01,
        FILL   = 2'b10,
        WRITE  = 2'b11
    } sb_drain_state_e;

endpackage

// File: rtl/segre_store_lane_align.sv
// Store lane alignment: places a LSB-aligned store operand on the dcache
// byte lanes and produces the matching byte enables.
module segre_store_lane_align
    import segre_pkg::*;
(
    input  logic [1:0]        offset,
    input  memop_data_type_e  mem_type,
    input  logic [WORD_W-1:0] data_in,
    output logic [BE_W-1:0]   be,
    output logic [WORD_W-1:0] data_out,
    output logic              misaligned
);

    // Lane replication and enables; misaligned accesses write no bytes
    always_comb begin
        be         = '0;
        data_out   = data_in;
        misaligned = 1'b0;
        unique case (mem_type)
            BYTE: begin
                be       = 4'b0001 << offset;
                data_out = {4{data_in[7:0]}};
            end
            HALF: begin
                be         = 4'b0011 << {offset[1], 1'b0};
                data_out   = {2{data_in[15:0]}};
                misaligned = offset[0];
            end
            WORD: begin
                be         = 4'hF;
                misaligned = (offset != 2'b00);
            end
            default: misaligned = 1'b1;
        endcase
        if (misaligned) be = '0;
    end

endmodule

// File: rtl/segre_sb_drain_unit.sv
// Store buffer drain: grants flush slots when loads leave the dcache idle,
// looks up the popped store, fills the line on a miss, then writes it.
module segre_sb_drain_unit
    import segre_pkg::*;
#(
    parameter int unsigned ADDR_SIZE  = 32,
    parameter int unsigned WORD_SIZE  = WORD_W,
    parameter int unsigned MISS_CNT_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ld_req_i,
    output logic                  flush_chance_o,
    input  logic                  sb_valid_i,
    input  logic [ADDR_SIZE-1:0]  sb_addr_i,
    input  logic [WORD_SIZE-1:0]  sb_data_i,
    input  memop_data_type_e      sb_type_i,
    output logic                  dc_lookup_o,
    input  logic                  dc_rsp_valid_i,
    input  logic                  dc_hit_i,
    output logic                  dc_fill_req_o,
    input  logic                  dc_fill_done_i,
    output logic                  dc_we_o,
    output logic [ADDR_SIZE-1:0]  dc_addr_o,
    output logic [WORD_SIZE-1:0]  dc_data_o,
    output logic [3:0]            dc_be_o,
    output logic                  busy_o,
    output logic [MISS_CNT_W-1:0] miss_cnt_o
);

    sb_drain_state_e          state;
    logic                     hold_valid;
    logic [ADDR_SIZE-1:0]     hold_addr;
    logic [WORD_SIZE-1:0]     hold_data;
    memop_data_type_e         hold_type;
    logic [BE_W-1:0]          al_be;
    logic [WORD_W-1:0]        al_data;
    logic                     al_bad;

    segre_store_lane_align u_align (
        .offset     (hold_addr[1:0]),
        .mem_type   (hold_type),
        .data_in    (hold_data),
        .be         (al_be),
        .data_out   (al_data),
        .misaligned (al_bad)
    );

    // Loads own the dcache port; a flush slot exists only when idle
    assign flush_chance_o = (state == IDLE) & ~ld_req_i & ~rst_i;
    assign busy_o         = (state != IDLE);
    assign dc_addr_o      = hold_addr;
    assign dc_data_o      = hold_valid ? al_data : '0;
    assign dc_be_o        = hold_valid ? al_be   : '0;

    // Drain FSM, holding register, registered strobes and miss counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            hold_valid    <= 1'b0;
            hold_addr     <= '0;
            hold_data     <= '0;
            hold_type     <= BYTE;
            dc_lookup_o   <= 1'b0;
            dc_fill_req_o <= 1'b0;
            dc_we_o       <= 1'b0;
            miss_cnt_o    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (flush_chance_o && sb_valid_i) begin
                        hold_valid  <= 1'b1;
                        hold_addr   <= sb_addr_i;
                        hold_data   <= sb_data_i;
                        hold_type   <= sb_type_i;
                        dc_lookup_o <= 1'b1;
                        state       <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (dc_rsp_valid_i) begin
                        dc_lookup_o <= 1'b0;
                        if (dc_hit_i) begin
                            dc_we_o <= 1'b1;
                            state   <= WRITE;
                        end else begin
                            dc_fill_req_o <= 1'b1;
                            state         <= FILL;
                            if (miss_cnt_o != {MISS_CNT_W{1'b1}})
                                miss_cnt_o <= miss_cnt_o + MISS_CNT_W'(1);
                        end
                    end
                end
                FILL: begin
                    if (dc_fill_done_i) begin
                        dc_fill_req_o <= 1'b0;
                        dc_we_o       <= 1'b1;
                        state         <= WRITE;
                    end
                end
                WRITE: begin
                    dc_we_o    <= 1'b0;
                    hold_valid <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Upstream filters misaligned stores; catch any that slip through
    a_lane_legal: assert property (
        @(posedge clk_i) disable iff (rst_i)
        (state == WRITE) |-> !al_bad
    );

endmodule

// File: tb/tb_segre_sb_drain_unit.sv
// Bench for the store buffer drain unit: directed table, corner
// sequences and randomized stores against a transaction-level model.
`timescale 1ns/1ps
module tb_segre_sb_drain_unit;
    import segre_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             ld_req;
    logic             sb_valid;
    logic [31:0]      sb_addr;
    logic [31:0]      sb_data;
    memop_data_type_e sb_type;
    logic             rsp_valid;
    logic             hit;
    logic             fill_done;

    logic        flush, lookup, fill, we, busy;
    logic [31:0] addr, data;
    logic [3:0]  be;
    logic [15:0] miss_cnt;

    logic        s_flush, s_lookup, s_fill, s_we, s_busy;
    logic [31:0] s_addr, s_data;
    logic [3:0]  s_be;
    logic [5:0]  s_miss;

    int n_cmp = 0;
    int n_bad = 0;
    int model_misses = 0;

    always #5 clk = ~clk;

    segre_sb_drain_unit u_dut (
        .clk_i(clk), .rst_i(rst), .ld_req_i(ld_req),
        .flush_chance_o(flush), .sb_valid_i(sb_valid),
        .sb_addr_i(sb_addr), .sb_data_i(sb_data), .sb_type_i(sb_type),
        .dc_lookup_o(lookup), .dc_rsp_valid_i(rsp_valid),
        .dc_hit_i(hit), .dc_fill_req_o(fill),
        .dc_fill_done_i(fill_done), .dc_we_o(we), .dc_addr_o(addr),
        .dc_data_o(data), .dc_be_o(be), .busy_o(busy),
        .miss_cnt_o(miss_cnt)
    );

    // Narrow-counter instance so saturation is reachable quickly
    segre_sb_drain_unit #(.MISS_CNT_W(6)) u_small (
        .clk_i(clk), .rst_i(rst), .ld_req_i(ld_req),
        .flush_chance_o(s_flush), .sb_valid_i(sb_valid),
        .sb_addr_i(sb_addr), .sb_data_i(sb_data), .sb_type_i(sb_type),
        .dc_lookup_o(s_lookup), .dc_rsp_valid_i(rsp_valid),
        .dc_hit_i(hit), .dc_fill_req_o(s_fill),
        .dc_fill_done_i(fill_done), .dc_we_o(s_we), .dc_addr_o(s_addr),
        .dc_data_o(s_data), .dc_be_o(s_be), .busy_o(s_busy),
        .miss_cnt_o(s_miss)
    );

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] ref_be(logic [31:0] a, memop_data_type_e t);
        int sz = 1 << int'(t);
        int m  = (1 << sz) - 1;
        return 4'(m << int'(a[1:0]));
    endfunction

    function automatic logic [31:0] ref_data(logic [31:0] d, memop_data_type_e t);
        int sz = 1 << int'(t);
        logic [63:0] m = (64'h1 << (8 * sz)) - 64'h1;
        logic [63:0] r = '0;
        for (int k = 0; k < 4 / sz; k++)
            r = r | ((64'(d) & m) << (8 * sz * k));
        return r[31:0];
    endfunction

    function automatic logic [15:0] ref_cnt16();
        return (model_misses > 65535) ? 16'hFFFF : 16'(model_misses);
    endfunction

    function automatic logic [5:0] ref_cnt6();
        return (model_misses > 63) ? 6'h3F : 6'(model_misses);
    endfunction

    // One complete store transaction starting from IDLE
    task automatic run_store(logic [31:0] a, logic [31:0] d,
                             memop_data_type_e t, logic h,
                             int rsp_dly, int fill_cyc,
                             logic [3:0] ebe, logic [31:0] edata);
        ld_req   = 1'b0;
        sb_valid = 1'b1;
        sb_addr  = a;
        sb_data  = d;
        sb_type  = t;
        #1;
        chk("flush_chance_idle", {s_flush, flush}, 2'b11);
        tick();
        sb_valid = 1'b0;
        sb_addr  = $urandom;
        sb_data  = $urandom;
        #1;
        chk("lookup_state", {lookup, busy, addr}, {2'b11, a});
        chk("s_lookup_state", {s_lookup, s_busy, s_addr}, {2'b11, a});
        chk("be_held", be, ebe);
        for (int i = 0; i < rsp_dly; i++) begin
            ld_req = 1'($urandom);
            #1;
            chk("no_flush_busy", {flush, lookup}, 2'b01);
            tick();
        end
        ld_req    = 1'b0;
        rsp_valid = 1'b1;
        hit       = h;
        tick();
        rsp_valid = 1'b0;
        hit       = 1'($urandom);
        #1;
        if (!h) begin
            model_misses++;
            chk("miss_cnt", miss_cnt, ref_cnt16());
            chk("s_miss_cnt", s_miss, ref_cnt6());
            for (int i = 0; i < fill_cyc; i++) begin
                chk("fill_req", {fill, s_fill, we, data}, {3'b110, edata});
                if (i == fill_cyc - 1) fill_done = 1'b1;
                tick();
                fill_done = 1'b0;
                #1;
            end
        end
        chk("write", {we, fill, be, data, addr},
            {2'b10, ebe, edata, a});
        chk("s_write", {s_we, s_be, s_data}, {1'b1, ebe, edata});
        tick();
        #1;
        chk("write_done", {we, busy, flush, fill}, 4'b0010);
    endtask

    typedef struct {
        logic [31:0]      a;
        logic [31:0]      d;
        memop_data_type_e t;
        logic             h;
        int               rsp_dly;
        int               fill_cyc;
        logic [3:0]       ebe;
        logic [31:0]      edata;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{32'h100, 32'hDEADBEEF, WORD, 1'b1, 0, 0, 4'hF, 32'hDEADBEEF};
        vecs[1] = '{32'h103, 32'h000000AB, BYTE, 1'b1, 0, 0, 4'h8, 32'hABABABAB};
        vecs[2] = '{32'h102, 32'h00001234, HALF, 1'b1, 2, 0, 4'hC, 32'h12341234};
        vecs[3] = '{32'h101, 32'h0000005A, BYTE, 1'b0, 0, 5, 4'h2, 32'h5A5A5A5A};
        vecs[4] = '{32'h200, 32'hCAFEBEEF, HALF, 1'b0, 1, 2, 4'h3, 32'hBEEFBEEF};
        vecs[5] = '{32'h3FC, 32'h01020304, WORD, 1'b0, 3, 1, 4'hF, 32'h01020304};

        rst = 1'b1; ld_req = 1'b0; sb_valid = 1'b0;
        sb_addr = '0; sb_data = '0; sb_type = BYTE;
        rsp_valid = 1'b0; hit = 1'b0; fill_done = 1'b0;
        tick();
        tick();
        chk("reset_outputs",
            {flush, lookup, fill, we, busy, be, data, addr, miss_cnt},
            '0);
        rst = 1'b0;
        #1;
        chk("reset_release_flush", flush, 1'b1);

        // Reset in the middle of a line fill
        sb_valid = 1'b1; sb_addr = 32'h200; sb_type = WORD;
        sb_data = 32'h11223344;
        tick();
        sb_valid = 1'b0; rsp_valid = 1'b1; hit = 1'b0;
        tick();
        rsp_valid = 1'b0;
        tick();
        chk("midfill_req", {fill, busy, miss_cnt}, {2'b11, 16'd1});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("midfill_reset", {fill, busy, we, miss_cnt}, '0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midfill_no_we", {we, fill, busy}, 3'b000);
        end
        model_misses = 0;

        for (int i = 0; i < 6; i++)
            run_store(vecs[i].a, vecs[i].d, vecs[i].t, vecs[i].h,
                      vecs[i].rsp_dly, vecs[i].fill_cyc,
                      vecs[i].ebe, vecs[i].edata);

        // Load priority blocks capture
        ld_req = 1'b1; sb_valid = 1'b1; sb_addr = 32'h400;
        #1;
        chk("prio_flush", flush, 1'b0);
        tick();
        chk("prio_no_capture", {busy, lookup}, 2'b00);
        ld_req = 1'b0; sb_valid = 1'b0;

        // Randomized legal stores with load interference between them
        for (int n = 0; n < 40; n++) begin
            logic [31:0]      a;
            logic [31:0]      d;
            memop_data_type_e t;
            int gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                ld_req   = 1'($urandom);
                sb_valid = ld_req & 1'($urandom);
                #1;
                chk("gap_flush", flush, !ld_req);
                tick();
                chk("gap_idle", busy, 1'b0);
            end
            sb_valid = 1'b0;
            t = memop_data_type_e'($urandom_range(0, 2));
            a = $urandom;
            if (t == HALF) a[0] = 1'b0;
            if (t == WORD) a[1:0] = 2'b00;
            d = $urandom;
            run_store(a, d, t, 1'($urandom), $urandom_range(0, 3),
                      $urandom_range(1, 4), ref_be(a, t), ref_data(d, t));
        end

        // Drive enough misses to saturate the narrow counter
        for (int n = 0; n < 70; n++)
            run_store(32'h40, 32'h55, BYTE, 1'b0, 0, 1,
                      ref_be(32'h40, BYTE), ref_data(32'h55, BYTE));
        chk("sat_small", s_miss, 6'h3F);
        chk("sat_main", miss_cnt, ref_cnt16());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
